// File: rtl/cpu_pipelined.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with EX forwarding, load-use stall and EX-resolved control flow.
// Memories and register file are internal; contents are loaded and observed hierarchically.

module cpu_imem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [31:0]              addr,
  output logic [31:0]              rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic        unused_addr_bits;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata            = mem[addr[AW+1:2]];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
endmodule

module cpu_dmem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic        unused_addr_bits;

  always_ff @(posedge clk) begin
    if (we) mem[addr[AW+1:2]] <= wdata;
  end

  assign rdata            = mem[addr[AW+1:2]];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] registers [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      registers[waddr] <= wdata;
    end
  end

  // Same-cycle WB write is visible to the ID read.
  always_comb begin
    rdata_a = registers[raddr_a];
    rdata_b = registers[raddr_b];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (raddr_a == 5'd0) rdata_a = '0;
    if (raddr_b == 5'd0) rdata_b = '0;
  end
endmodule

module cpu_pipelined #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned IA_W = $clog2(IMEM_DEPTH);
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_t;

  logic [31:0] pc, instruction, if_id_pc, if_id_instruction;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        stall, flush;

  logic        f3_legal;
  alu_op_t     f3_alu;
  logic        dec_legal, dec_use_rs1, dec_use_rs2, dec_use_imm;
  alu_op_t     dec_alu_op;
  logic [31:0] dec_imm;

  logic [6:0]  id_ex_opcode;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
  alu_op_t     id_ex_alu_op;
  logic        id_ex_use_imm, id_ex_bne;
  logic        id_ex_jal, id_ex_branch, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;

  logic [1:0]  forward_a, forward_b;
  logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_result, branch_target;

  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data;
  logic [4:0]  ex_mem_rd_addr;
  logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;

  logic [31:0] mem_rdata, mem_wb_alu_result, mem_wb_mem_rdata, rd_data_wb;
  logic [4:0]  mem_wb_rd_addr;
  logic        mem_wb_reg_write_enable, mem_wb_mem_to_reg;

  cpu_imem #(.DEPTH(IMEM_DEPTH)) instruction_memory (
    .clk(clk), .we(1'b0), .waddr(IA_W'(0)), .wdata(32'd0), .addr(pc), .rdata(instruction)
  );

  cpu_dmem #(.DEPTH(DMEM_DEPTH)) data_memory (
    .clk(clk), .we(ex_mem_mem_write), .addr(ex_mem_alu_result), .wdata(ex_mem_rs2_data),
    .rdata(mem_rdata)
  );

  cpu_regfile register_file_init (
    .clk(clk), .reset(reset), .we(mem_wb_reg_write_enable), .waddr(mem_wb_rd_addr),
    .wdata(rd_data_wb), .raddr_a(rs1_addr), .raddr_b(rs2_addr),
    .rdata_a(rs1_data), .rdata_b(rs2_data)
  );

  // IF: pc and IF/ID; redirect beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                <= '0;
      if_id_pc          <= '0;
      if_id_instruction <= '0;
    end else if (flush) begin
      pc                <= branch_target;
      if_id_pc          <= '0;
      if_id_instruction <= '0;
    end else if (!stall) begin
      pc                <= pc + 32'd4;
      if_id_pc          <= pc;
      if_id_instruction <= instruction;
    end
  end

  assign opcode   = if_id_instruction[6:0];
  assign rd_addr  = if_id_instruction[11:7];
  assign funct3   = if_id_instruction[14:12];
  assign rs1_addr = if_id_instruction[19:15];
  assign rs2_addr = if_id_instruction[24:20];
  assign funct7   = if_id_instruction[31:25];

  assign imm_i = {{20{if_id_instruction[31]}}, if_id_instruction[31:20]};
  assign imm_s = {{20{if_id_instruction[31]}}, if_id_instruction[31:25], if_id_instruction[11:7]};
  assign imm_b = {{19{if_id_instruction[31]}}, if_id_instruction[31], if_id_instruction[7],
                  if_id_instruction[30:25], if_id_instruction[11:8], 1'b0};
  assign imm_j = {{11{if_id_instruction[31]}}, if_id_instruction[31], if_id_instruction[19:12],
                  if_id_instruction[20], if_id_instruction[30:21], 1'b0};

  always_comb begin
    f3_legal = 1'b1;
    f3_alu   = ALU_ADD;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b010:  f3_alu = ALU_SLT;
      3'b100:  f3_alu = ALU_XOR;
      3'b110:  f3_alu = ALU_OR;
      3'b111:  f3_alu = ALU_AND;
      default: f3_legal = 1'b0;
    endcase
  end

  // Decode; unsupported encodings leave dec_legal low and become NOPs.
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_use_imm = 1'b0;
    dec_alu_op  = ALU_ADD;
    dec_imm     = '0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h00 && f3_legal) begin
          dec_legal  = 1'b1;
          dec_alu_op = f3_alu;
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          dec_legal  = 1'b1;
          dec_alu_op = ALU_SUB;
        end
        dec_use_rs1 = dec_legal;
        dec_use_rs2 = dec_legal;
      end
      OP_I: begin
        dec_legal   = f3_legal;
        dec_use_rs1 = f3_legal;
        dec_use_imm = 1'b1;
        dec_alu_op  = f3_alu;
        dec_imm     = imm_i;
      end
      OP_LW: begin
        dec_legal   = (funct3 == 3'b010);
        dec_use_rs1 = dec_legal;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
      end
      OP_SW: begin
        dec_legal   = (funct3 == 3'b010);
        dec_use_rs1 = dec_legal;
        dec_use_rs2 = dec_legal;
        dec_use_imm = 1'b1;
        dec_imm     = imm_s;
      end
      OP_BR: begin
        dec_legal   = (funct3 == 3'b000 || funct3 == 3'b001);
        dec_use_rs1 = dec_legal;
        dec_use_rs2 = dec_legal;
        dec_imm     = imm_b;
      end
      OP_JAL: begin
        dec_legal = 1'b1;
        dec_imm   = imm_j;
      end
      default: ;
    endcase
  end

  assign stall = id_ex_mem_read && id_ex_rd_addr != 5'd0 &&
                 ((dec_use_rs1 && id_ex_rd_addr == rs1_addr) ||
                  (dec_use_rs2 && id_ex_rd_addr == rs2_addr));

  // ID/EX: a bubble is an all-zero opcode, which disables every write and redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_opcode   <= '0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1_addr <= '0;
      id_ex_rs2_addr <= '0;
      id_ex_rd_addr  <= '0;
      id_ex_alu_op   <= ALU_ADD;
      id_ex_use_imm  <= 1'b0;
      id_ex_bne      <= 1'b0;
    end else begin
      id_ex_opcode   <= (dec_legal && !flush && !stall) ? opcode : 7'h00;
      id_ex_pc       <= if_id_pc;
      id_ex_rs1_data <= rs1_data;
      id_ex_rs2_data <= rs2_data;
      id_ex_imm      <= dec_imm;
      id_ex_rs1_addr <= dec_use_rs1 ? rs1_addr : 5'd0;
      id_ex_rs2_addr <= dec_use_rs2 ? rs2_addr : 5'd0;
      id_ex_rd_addr  <= rd_addr;
      id_ex_alu_op   <= dec_alu_op;
      id_ex_use_imm  <= dec_use_imm;
      id_ex_bne      <= funct3[0];
    end
  end

  assign id_ex_jal       = (id_ex_opcode == OP_JAL);
  assign id_ex_branch    = (id_ex_opcode == OP_BR);
  assign id_ex_mem_read  = (id_ex_opcode == OP_LW);
  assign id_ex_mem_write = (id_ex_opcode == OP_SW);
  assign id_ex_reg_write = (id_ex_opcode == OP_R) || (id_ex_opcode == OP_I) ||
                           id_ex_mem_read || id_ex_jal;

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_mem_reg_write && ex_mem_rd_addr != 5'd0 && ex_mem_rd_addr == id_ex_rs1_addr)
      forward_a = 2'b10;
    else if (mem_wb_reg_write_enable && mem_wb_rd_addr != 5'd0 && mem_wb_rd_addr == id_ex_rs1_addr)
      forward_a = 2'b01;
    if (ex_mem_reg_write && ex_mem_rd_addr != 5'd0 && ex_mem_rd_addr == id_ex_rs2_addr)
      forward_b = 2'b10;
    else if (mem_wb_reg_write_enable && mem_wb_rd_addr != 5'd0 && mem_wb_rd_addr == id_ex_rs2_addr)
      forward_b = 2'b01;
  end

  always_comb begin
    case (forward_a)
      2'b10:   fwd_a = ex_mem_alu_result;
      2'b01:   fwd_a = rd_data_wb;
      default: fwd_a = id_ex_rs1_data;
    endcase
    case (forward_b)
      2'b10:   fwd_b = ex_mem_alu_result;
      2'b01:   fwd_b = rd_data_wb;
      default: fwd_b = id_ex_rs2_data;
    endcase
  end

  // JAL reuses the adder to produce its link value pc+4.
  assign alu_a = id_ex_jal ? id_ex_pc : fwd_a;
  assign alu_b = id_ex_jal ? 32'd4 : (id_ex_use_imm ? id_ex_imm : fwd_b);

  always_comb begin
    case (id_ex_alu_op)
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_SLT: alu_result = 32'($signed(alu_a) < $signed(alu_b));
      default: alu_result = alu_a + alu_b;
    endcase
  end

  assign branch_target = id_ex_pc + id_ex_imm;
  assign flush         = id_ex_jal || (id_ex_branch && ((fwd_a == fwd_b) != id_ex_bne));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_alu_result <= '0;
      ex_mem_rs2_data   <= '0;
      ex_mem_rd_addr    <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else begin
      ex_mem_alu_result <= alu_result;
      ex_mem_rs2_data   <= fwd_b;
      ex_mem_rd_addr    <= id_ex_rd_addr;
      ex_mem_reg_write  <= id_ex_reg_write;
      ex_mem_mem_read   <= id_ex_mem_read;
      ex_mem_mem_write  <= id_ex_mem_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_alu_result       <= '0;
      mem_wb_mem_rdata        <= '0;
      mem_wb_rd_addr          <= '0;
      mem_wb_reg_write_enable <= 1'b0;
      mem_wb_mem_to_reg       <= 1'b0;
    end else begin
      mem_wb_alu_result       <= ex_mem_alu_result;
      mem_wb_mem_rdata        <= mem_rdata;
      mem_wb_rd_addr          <= ex_mem_rd_addr;
      mem_wb_reg_write_enable <= ex_mem_reg_write;
      mem_wb_mem_to_reg       <= ex_mem_mem_read;
    end
  end

  assign rd_data_wb = mem_wb_mem_to_reg ? mem_wb_mem_rdata : mem_wb_alu_result;
endmodule

// File: tb/tb_cpu_pipelined.sv
// Directed bench for cpu_pipelined: hand-assembled programs loaded hierarchically,
// architectural state and hazard activity checked against hand-computed values.

module tb_cpu_pipelined;
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   stall_cycles = 0;
  int   flush_cycles = 0;
  bit   count_en = 1'b0;
  logic [31:0] prog [$];

  cpu_pipelined #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en) begin
      if (dut.stall === 1'b1) stall_cycles++;
      if (dut.flush === 1'b1) flush_cycles++;
    end
  end

  function automatic logic [31:0] ei(input int imm, input int rs1, input logic [2:0] f3,
                                     input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] er(input logic [6:0] f7, input int rs2, input int rs1,
                                     input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_R};
  endfunction

  function automatic logic [31:0] es(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] ej(input int imm, input int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.instruction_memory.mem[i] <= (i < prog.size()) ? prog[i] : 32'd0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    stall_cycles = 0;
    flush_cycles = 0;
    count_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.instruction_memory.mem[i] <= 32'd0;
      dut.data_memory.mem[i]        <= 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", dut.pc); end
    checks++; if (dut.if_id_instruction !== 32'd0) begin errors++; $display("FAIL reset_if_id: got %h expected 00000000", dut.if_id_instruction); end
    checks++; if (dut.id_ex_opcode !== 7'd0) begin errors++; $display("FAIL reset_id_ex_opcode: got %h expected 00", dut.id_ex_opcode); end
    checks++; if (dut.mem_wb_reg_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", dut.mem_wb_reg_write_enable); end
    checks++; if (dut.register_file_init.registers[7] !== 32'd0) begin errors++; $display("FAIL reset_x7: got %h expected 00000000", dut.register_file_init.registers[7]); end
  endtask

  // Full mixed sequence: forwarding, load-use, taken/not-taken branch, JAL, loads.
  task automatic test_main_program();
    int          r_idx [25];
    logic [31:0] r_exp [25];
    reset = 1'b1;
    prog.delete();
    prog.push_back(ei(1, 0, 3'b000, 1, OP_I));
    prog.push_back(ei(2, 0, 3'b000, 2, OP_I));
    prog.push_back(ei(3, 0, 3'b000, 3, OP_I));
    prog.push_back(er(7'h00, 2, 1, 3'b000, 5));
    prog.push_back(er(7'h00, 5, 3, 3'b000, 6));
    prog.push_back(ei(0, 0, 3'b010, 9, OP_LW));
    prog.push_back(ei(0, 9, 3'b000, 10, OP_I));
    prog.push_back(es(4, 5, 10));
    prog.push_back(ei(1, 1, 3'b000, 13, OP_I));
    prog.push_back(eb(8, 13, 2, 3'b000));
    prog.push_back(ei(-1, 0, 3'b000, 14, OP_I));
    prog.push_back(ei(6, 0, 3'b000, 15, OP_I));
    prog.push_back(eb(8, 2, 1, 3'b000));
    prog.push_back(ei(5, 0, 3'b000, 19, OP_I));
    prog.push_back(ei(7, 2, 3'b100, 11, OP_I));
    prog.push_back(ei(-16, 0, 3'b110, 7, OP_I));
    prog.push_back(ei(1, 7, 3'b010, 8, OP_I));
    prog.push_back(ei(255, 7, 3'b111, 4, OP_I));
    prog.push_back(ej(8, 16));
    prog.push_back(ei(-1, 0, 3'b000, 17, OP_I));
    prog.push_back(ei(7, 0, 3'b000, 18, OP_I));
    prog.push_back(er(7'h20, 2, 1, 3'b000, 25));
    prog.push_back(er(7'h00, 2, 1, 3'b111, 26));
    prog.push_back(er(7'h00, 2, 1, 3'b110, 27));
    prog.push_back(ei(4, 20, 3'b010, 22, OP_LW));
    prog.push_back(ei(12, 20, 3'b010, 23, OP_LW));
    prog.push_back(er(7'h00, 23, 22, 3'b000, 24));
    load_prog();
    dut.data_memory.mem[0] <= 32'd4;
    dut.data_memory.mem[1] <= 32'd8;
    dut.data_memory.mem[3] <= 32'd8;
    #1;
    release_reset();

    repeat (4) @(posedge clk);
    #1;
    checks++; if (dut.register_file_init.registers[1] !== 32'd0) begin errors++; $display("FAIL wb_edge4_x1: got %h expected 00000000", dut.register_file_init.registers[1]); end
    checks++; if (dut.pc !== 32'd16) begin errors++; $display("FAIL pc_after_4: got %h expected 00000010", dut.pc); end
    @(posedge clk);
    #1;
    checks++; if (dut.register_file_init.registers[1] !== 32'd1) begin errors++; $display("FAIL wb_edge5_x1: got %h expected 00000001", dut.register_file_init.registers[1]); end

    repeat (33) @(posedge clk);
    #1;
    count_en = 1'b0;

    r_idx = '{1, 2, 3, 5, 6, 9, 10, 13, 14, 15, 19, 11, 7, 8, 4,
              16, 17, 18, 25, 26, 27, 22, 23, 24, 0};
    r_exp = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd6, 32'd4, 32'd4, 32'd2, 32'd0, 32'd6, 32'd5,
              32'd5, 32'hFFFF_FFF0, 32'd1, 32'h0000_00F0, 32'd76, 32'd0, 32'd7,
              32'hFFFF_FFFF, 32'd0, 32'd3, 32'd8, 32'd8, 32'h10, 32'd0};
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (dut.register_file_init.registers[r_idx[i]] !== r_exp[i]) begin
        errors++;
        $display("FAIL main_x%0d: got %h expected %h", r_idx[i], dut.register_file_init.registers[r_idx[i]], r_exp[i]);
      end
    end
    checks++; if (dut.data_memory.mem[2] !== 32'd3) begin errors++; $display("FAIL main_dmem2: got %h expected 00000003", dut.data_memory.mem[2]); end
    checks++; if (stall_cycles != 2) begin errors++; $display("FAIL main_stall_cycles: got %0d expected 2", stall_cycles); end
    checks++; if (flush_cycles != 2) begin errors++; $display("FAIL main_flush_cycles: got %0d expected 2", flush_cycles); end
  endtask

  // Asynchronous reset mid-run clears pc and registers, leaves both memories alone.
  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL areset_pc: got %h expected 00000000", dut.pc); end
    checks++; if (dut.register_file_init.registers[5] !== 32'd0) begin errors++; $display("FAIL areset_x5: got %h expected 00000000", dut.register_file_init.registers[5]); end
    checks++; if (dut.data_memory.mem[2] !== 32'd3) begin errors++; $display("FAIL areset_dmem2: got %h expected 00000003", dut.data_memory.mem[2]); end
    checks++; if (dut.instruction_memory.mem[0] !== ei(1, 0, 3'b000, 1, OP_I)) begin errors++; $display("FAIL areset_imem0: got %h expected %h", dut.instruction_memory.mem[0], ei(1, 0, 3'b000, 1, OP_I)); end
  endtask

  // x0 writes, unsupported encodings, WB->ID bypass and register-register ops.
  task automatic test_nop_bypass();
    int          r_idx [10];
    logic [31:0] r_exp [10];
    reset = 1'b1;
    prog.delete();
    prog.push_back(ei(5, 0, 3'b000, 0, OP_I));
    prog.push_back(32'hFFFF_FFFF);
    prog.push_back(ei(9, 0, 3'b000, 1, OP_I));
    prog.push_back(ei(1, 0, 3'b000, 2, OP_I));
    prog.push_back(ei(2, 0, 3'b000, 3, OP_I));
    prog.push_back(er(7'h00, 0, 1, 3'b000, 4));
    prog.push_back(er(7'h00, 3, 1, 3'b100, 5));
    prog.push_back(ei(-3, 0, 3'b000, 7, OP_I));
    prog.push_back(er(7'h00, 1, 7, 3'b010, 8));
    prog.push_back(er(7'h00, 7, 1, 3'b010, 9));
    prog.push_back(er(7'h00, 1, 1, 3'b001, 10));
    prog.push_back(eb(8, 1, 0, 3'b100));
    prog.push_back(ei(3, 0, 3'b000, 11, OP_I));
    load_prog();
    release_reset();
    repeat (25) @(posedge clk);
    #1;
    count_en = 1'b0;

    r_idx = '{0, 31, 1, 4, 5, 7, 8, 9, 10, 11};
    r_exp = '{32'd0, 32'd0, 32'd9, 32'd9, 32'd11, 32'hFFFF_FFFD, 32'd1, 32'd0, 32'd0, 32'd3};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut.register_file_init.registers[r_idx[i]] !== r_exp[i]) begin
        errors++;
        $display("FAIL nop_x%0d: got %h expected %h", r_idx[i], dut.register_file_init.registers[r_idx[i]], r_exp[i]);
      end
    end
    checks++; if (flush_cycles != 0) begin errors++; $display("FAIL nop_flush_cycles: got %0d expected 0", flush_cycles); end
    checks++; if (stall_cycles != 0) begin errors++; $display("FAIL nop_stall_cycles: got %0d expected 0", stall_cycles); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_main_program();
    test_async_reset();
    test_nop_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
